// File: rtl/read_bus_sink_pkg.sv
// Shared definitions for the read-bus sink: destination map, FSM states,
// default widths and the target table used by the permission decoder.
package read_bus_sink_pkg;

    localparam int WRITE_WIDTH   = 8;
    localparam int ADDR_WIDTH    = 5;
    localparam int MPC_WIDTH     = 8;
    localparam int ERR_CNT_WIDTH = 8;

    // Destination codes carried on reg_dst
    typedef enum logic [ADDR_WIDTH-1:0] {
        DST_A_REG       = 5'd0,
        DST_B_REG       = 5'd1,
        DST_REG_SEL     = 5'd5,
        DST_REG_WR_DATA = 5'd6,
        DST_M_PC        = 5'd12
    } bus_dst_e;

    // Two-phase handshake: accept in IDLE, write back in COMMIT
    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_e;

    // One-hot target bit positions; the first four are WRITE_WIDTH registers
    localparam int NUM_TGT  = 5;
    localparam int NUM_DATA = 4;
    localparam int TGT_A    = 0;
    localparam int TGT_B    = 1;
    localparam int TGT_SEL  = 2;
    localparam int TGT_WR   = 3;
    localparam int TGT_MPC  = 4;

    // Destination code for each one-hot target position
    localparam bus_dst_e TGT_DST [NUM_TGT] = '{
        DST_A_REG, DST_B_REG, DST_REG_SEL, DST_REG_WR_DATA, DST_M_PC
    };

endpackage

// File: rtl/read_bus_permit.sv
// Combinational destination decoder: turns a latched reg_dst plus the bus
// enables into a one-hot target vector and a single permit bit. Unmapped
// destinations produce an all-zero target and are never permitted.
module read_bus_permit
    import read_bus_sink_pkg::*;
#(
    parameter int ADDR_WIDTH = read_bus_sink_pkg::ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] dst,
    input  logic                  alu_en,
    input  logic                  reg_file_en,
    input  logic                  reg_file_rw,
    input  logic                  is_branch,
    output logic [NUM_TGT-1:0]    target,
    output logic                  permit
);

    logic [NUM_TGT-1:0] allow;

    // Which enable unlocks each target
    always_comb begin
        allow          = '0;
        allow[TGT_A]   = alu_en;
        allow[TGT_B]   = alu_en;
        allow[TGT_SEL] = reg_file_en;
        allow[TGT_WR]  = reg_file_en & reg_file_rw;
        allow[TGT_MPC] = is_branch;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TGT; gi++) begin : g_match
            assign target[gi] = (dst == ADDR_WIDTH'(TGT_DST[gi]));
        end
    endgenerate

    assign permit = |(target & allow);

endmodule

// File: rtl/read_bus_sink.sv
// Consumer end of the micro-op write bus. A transfer is latched on the accept
// edge (IDLE) and written to its destination on the following edge (COMMIT);
// writes whose destination is not enabled are dropped and flagged in bus_err.
// Optional: define READ_BUS_ERR_CNT_EN to build a saturating rejected-write
// counter on err_count; otherwise err_count is tied to zero.
module read_bus_sink
    import read_bus_sink_pkg::*;
#(
    parameter int WRITE_WIDTH = read_bus_sink_pkg::WRITE_WIDTH,
    parameter int ADDR_WIDTH  = read_bus_sink_pkg::ADDR_WIDTH,
    parameter int MPC_WIDTH   = read_bus_sink_pkg::MPC_WIDTH
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [WRITE_WIDTH-1:0]   write_bus,
    input  logic [ADDR_WIDTH-1:0]    reg_dst,
    input  logic                     alu_en,
    input  logic                     reg_file_en,
    input  logic                     reg_file_rw,
    input  logic                     is_branch,
    input  logic                     bus_valid,
    output logic                     bus_ready,
    input  logic                     err_clr,
    output logic [WRITE_WIDTH-1:0]   a_reg,
    output logic [WRITE_WIDTH-1:0]   b_reg,
    output logic [WRITE_WIDTH-1:0]   reg_sel,
    output logic [WRITE_WIDTH-1:0]   reg_wr_data,
    output logic                     reg_file_we,
    output logic [MPC_WIDTH-1:0]     m_pc_next,
    output logic                     m_pc_load,
    output logic                     commit_done,
    output logic                     bus_err,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    state_e                  state_reg;
    state_e                  state_next;
    logic                    accept;
    logic                    commit;

    logic [WRITE_WIDTH-1:0]  hold_data_reg;
    logic [ADDR_WIDTH-1:0]   hold_dst_reg;
    logic                    hold_alu_en_reg;
    logic                    hold_rf_en_reg;
    logic                    hold_rf_rw_reg;
    logic                    hold_branch_reg;

    logic [NUM_TGT-1:0]      target;
    logic                    permit;
    logic                    write_fire;
    logic                    reject;

    // FSM state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake decode; bus_ready depends on state only
    always_comb begin
        state_next = state_reg;
        bus_ready  = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                bus_ready = 1'b1;
                if (bus_valid) begin
                    accept     = 1'b1;
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Holding registers: data, destination and enables frozen at accept
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hold_data_reg   <= '0;
            hold_dst_reg    <= '0;
            hold_alu_en_reg <= 1'b0;
            hold_rf_en_reg  <= 1'b0;
            hold_rf_rw_reg  <= 1'b0;
            hold_branch_reg <= 1'b0;
        end else if (accept) begin
            hold_data_reg   <= write_bus;
            hold_dst_reg    <= reg_dst;
            hold_alu_en_reg <= alu_en;
            hold_rf_en_reg  <= reg_file_en;
            hold_rf_rw_reg  <= reg_file_rw;
            hold_branch_reg <= is_branch;
        end
    end

    read_bus_permit #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_permit (
        .dst         (hold_dst_reg),
        .alu_en      (hold_alu_en_reg),
        .reg_file_en (hold_rf_en_reg),
        .reg_file_rw (hold_rf_rw_reg),
        .is_branch   (hold_branch_reg),
        .target      (target),
        .permit      (permit)
    );

    assign write_fire = commit & permit;
    assign reject     = commit & ~permit;

    // Data-width destination registers, one per target slot
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DATA; gi++) begin : g_bank
            logic [WRITE_WIDTH-1:0] data_reg;

            // Load this slot when a permitted commit targets it
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    data_reg <= '0;
                end else if (write_fire && target[gi]) begin
                    data_reg <= hold_data_reg;
                end
            end
        end
    endgenerate

    assign a_reg       = g_bank[TGT_A].data_reg;
    assign b_reg       = g_bank[TGT_B].data_reg;
    assign reg_sel     = g_bank[TGT_SEL].data_reg;
    assign reg_wr_data = g_bank[TGT_WR].data_reg;

    // Micro-PC target: bus value resized to MPC_WIDTH, held between loads
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_pc_next <= '0;
        end else if (write_fire && target[TGT_MPC]) begin
            m_pc_next <= MPC_WIDTH'(hold_data_reg);
        end
    end

    // Registered one-cycle strobes following the commit edge
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            commit_done <= 1'b0;
            reg_file_we <= 1'b0;
            m_pc_load   <= 1'b0;
        end else begin
            commit_done <= commit;
            reg_file_we <= write_fire & target[TGT_WR];
            m_pc_load   <= write_fire & target[TGT_MPC];
        end
    end

    // Sticky error flag; a rejection on the same edge as err_clr keeps it set
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bus_err <= 1'b0;
        end else if (reject) begin
            bus_err <= 1'b1;
        end else if (err_clr) begin
            bus_err <= 1'b0;
        end
    end

`ifdef READ_BUS_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] err_cnt_reg;

    // Saturating rejected-write counter; clear with rejection restarts at 1
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            err_cnt_reg <= '0;
        end else if (reject && err_clr) begin
            err_cnt_reg <= ERR_CNT_WIDTH'(1);
        end else if (reject) begin
            if (err_cnt_reg != {ERR_CNT_WIDTH{1'b1}}) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end else if (err_clr) begin
            err_cnt_reg <= '0;
        end
    end

    assign err_count = err_cnt_reg;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_read_bus_sink.sv
// Scoreboard bench for read_bus_sink: the driver pushes the expected register
// image for every accepted transfer, a monitor pops it on each commit_done.
module tb_read_bus_sink;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] write_bus = '0;
    logic [4:0] reg_dst = '0;
    logic       alu_en = 1'b0, reg_file_en = 1'b0, reg_file_rw = 1'b0, is_branch = 1'b0;
    logic       bus_valid = 1'b0, err_clr = 1'b0;
    logic       bus_ready;
    logic [7:0] a_reg, b_reg, reg_sel, reg_wr_data, m_pc_next, err_count;
    logic       reg_file_we, m_pc_load, commit_done, bus_err;

`ifdef READ_BUS_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #5 sys_clk = ~sys_clk;

    read_bus_sink dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .write_bus   (write_bus),
        .reg_dst     (reg_dst),
        .alu_en      (alu_en),
        .reg_file_en (reg_file_en),
        .reg_file_rw (reg_file_rw),
        .is_branch   (is_branch),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .err_clr     (err_clr),
        .a_reg       (a_reg),
        .b_reg       (b_reg),
        .reg_sel     (reg_sel),
        .reg_wr_data (reg_wr_data),
        .reg_file_we (reg_file_we),
        .m_pc_next   (m_pc_next),
        .m_pc_load   (m_pc_load),
        .commit_done (commit_done),
        .bus_err     (bus_err),
        .err_count   (err_count)
    );

    typedef struct packed {
        logic [7:0] a, b, sel, wr, mpc;
        logic       we, load, err;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: architectural view of the sink after each commit
    logic [7:0] m_a, m_b, m_sel, m_wr, m_mpc;
    bit         m_err;
    int         m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_sel = 0; m_wr = 0; m_mpc = 0; m_err = 0; m_cnt = 0;
    endtask

    function automatic bit allowed(input int dst, input bit alu, input bit rfe, input bit rw, input bit br);
        case (dst)
            0, 1:    return alu;
            5:       return rfe;
            6:       return rfe && rw;
            12:      return br;
            default: return 1'b0;
        endcase
    endfunction

    // Apply one transfer to the model and queue the image seen at commit_done
    task automatic model_commit(input int dst, input logic [7:0] data, input bit alu,
                                input bit rfe, input bit rw, input bit br, input bit clr);
        exp_t e;
        bit   ok;
        ok     = allowed(dst, alu, rfe, rw, br);
        e.we   = 1'b0;
        e.load = 1'b0;
        if (ok) begin
            case (dst)
                0:  m_a = data;
                1:  m_b = data;
                5:  m_sel = data;
                6:  begin m_wr = data; e.we = 1'b1; end
                12: begin m_mpc = data; e.load = 1'b1; end
                default: ;
            endcase
            if (clr) begin m_err = 0; m_cnt = 0; end
        end else begin
            m_err = 1;
            if (clr) m_cnt = 1;
            else if (m_cnt < 255) m_cnt++;
        end
        e.a = m_a; e.b = m_b; e.sel = m_sel; e.wr = m_wr; e.mpc = m_mpc;
        e.err = m_err;
        e.cnt = CNT_EN ? 8'(m_cnt) : 8'd0;
        exp_q.push_back(e);
    endtask

    // Monitor: compare on every commit_done; strobes must never appear alone
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (commit_done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_commit: commit_done=1 with no transfer pending");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("commit", {a_reg, b_reg, reg_sel, reg_wr_data, m_pc_next,
                                     reg_file_we, m_pc_load, bus_err, err_count}, mon_e);
                end
            end else begin
                check("idle_strobes", {reg_file_we, m_pc_load}, 2'b00);
            end
        end
    end

    // One full transfer; inputs are scrambled during COMMIT to show they are ignored
    task automatic xfer(input int dst, input logic [7:0] data, input bit alu, input bit rfe,
                        input bit rw, input bit br, input bit clr_acc, input bit clr_com);
        int g = 0;
        while (bus_ready !== 1'b1) begin
            @(negedge sys_clk);
            g++;
            if (g > 20) begin
                n_checks++;
                $display("FAIL ready_timeout: bus_ready=%b required 1", bus_ready);
                return;
            end
        end
        write_bus = data; reg_dst = 5'(dst);
        alu_en = alu; reg_file_en = rfe; reg_file_rw = rw; is_branch = br;
        bus_valid = 1'b1; err_clr = clr_acc;
        @(posedge sys_clk); #1;
        if (clr_acc) begin m_err = 0; m_cnt = 0; end
        model_commit(dst, data, alu, rfe, rw, br, clr_com);
        check("ready_in_commit", bus_ready, 1'b0);
        write_bus = 8'($urandom); reg_dst = 5'($urandom);
        alu_en = 1'($urandom); reg_file_en = 1'($urandom);
        reg_file_rw = 1'($urandom); is_branch = 1'($urandom);
        bus_valid = 1'($urandom); err_clr = clr_com;
        @(posedge sys_clk); #1;
        bus_valid = 1'b0; err_clr = 1'b0;
    endtask

    int dst_tab[6] = '{0, 1, 5, 6, 12, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        // Reset state
        repeat (2) @(negedge sys_clk);
        check("reset_outputs", {a_reg, b_reg, reg_sel, reg_wr_data, m_pc_next, reg_file_we,
                                m_pc_load, commit_done, bus_err, err_count}, 0);
        check("reset_ready", bus_ready, 1'b1);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Reset arriving while a transfer sits in COMMIT
        xfer(0, 8'h11, 1, 0, 0, 0, 0, 0);
        @(negedge sys_clk);
        write_bus = 8'h5A; reg_dst = 5'd0; alu_en = 1'b1; bus_valid = 1'b1;
        @(posedge sys_clk); #1;
        bus_valid = 1'b0;
        check("midreset_in_commit", bus_ready, 1'b0);
        #2 sys_rst = 1'b1;
        #1 check("midreset_async", {a_reg, commit_done, bus_ready}, {8'h00, 1'b0, 1'b1});
        @(negedge sys_clk); @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();
        @(negedge sys_clk);
        check("midreset_after", {a_reg, commit_done, bus_ready}, {8'h00, 1'b0, 1'b1});

        // Directed writes
        xfer(1, 8'h3C, 1, 0, 0, 0, 0, 0);
        xfer(6, 8'hA7, 0, 1, 1, 0, 0, 0);
        xfer(6, 8'h55, 0, 1, 0, 0, 0, 0);
        xfer(12, 8'h42, 0, 0, 0, 1, 0, 0);
        xfer(12, 8'h99, 1, 1, 1, 0, 0, 0);
        xfer(5, 8'hC3, 0, 1, 0, 0, 0, 1);
        xfer(0, 8'h77, 0, 0, 0, 0, 0, 0);
        // err_clr while idle
        err_clr = 1'b1;
        @(posedge sys_clk); #1;
        err_clr = 1'b0; m_err = 0; m_cnt = 0;
        check("idle_err_clr", {bus_err, err_count}, 9'd0);

        // Back-to-back: valid held six cycles, accepts on every other edge
        for (int k = 0; k < 6; k++) begin
            reg_dst = 5'd0; alu_en = 1'b1; reg_file_en = 1'b0; is_branch = 1'b0;
            bus_valid = 1'b1;
            write_bus = (k % 2 == 0) ? 8'(k / 2 + 1) : 8'hEE;
            @(negedge sys_clk);
            check("b2b_ready", bus_ready, (k % 2 == 0) ? 1'b1 : 1'b0);
            @(posedge sys_clk); #1;
            if (k % 2 == 0) model_commit(0, 8'(k / 2 + 1), 1, 0, 0, 0, 0);
        end
        bus_valid = 1'b0;
        @(negedge sys_clk);

        // Error counter saturation, then clear coinciding with a rejection
        for (int i = 0; i < 260; i++) xfer(31, 8'(i), 1, 1, 1, 1, 0, 0);
        check("err_saturate", err_count, CNT_EN ? 8'd255 : 8'd0);
        xfer(31, 8'h00, 0, 0, 0, 0, 0, 1);
        xfer(0, 8'h21, 1, 0, 0, 0, 0, 1);

        // Randomised traffic
        for (int i = 0; i < 150; i++) begin
            int sel;
            int d;
            sel = int'($urandom_range(0, 5));
            d = (sel == 5) ? int'($urandom_range(0, 31)) : dst_tab[sel];
            xfer(d, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        repeat (4) @(negedge sys_clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
